// File: rtl/fifo_burst_sched_pkg.sv
// Shared encoding, widths and default sizing for the SDRAM burst scheduler.
package fifo_burst_sched_pkg;

    localparam int ADDR_W = 24;
    localparam int LEN_W  = 10;

    localparam logic [ADDR_W-1:0] DEF_ADDR_DEPTH  = 24'd1048576;
    localparam logic [LEN_W-1:0]  DEF_FIFO_DEPTH  = 10'd1023;
    localparam logic [15:0]       DEF_ACK_TIMEOUT = 16'd50000;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_WAIT,
        RD_REQ,
        RD_WAIT
    } state_t;

    // A burst never crosses the ring end, so it is cut to the room left before it.
    function automatic logic [LEN_W-1:0] clipLen(input logic [LEN_W-1:0]  burst,
                                                 input logic [ADDR_W-1:0] room);
        if ({{(ADDR_W-LEN_W){1'b0}}, burst} <= room) begin
            clipLen = burst;
        end else begin
            clipLen = room[LEN_W-1:0];
        end
    endfunction

endpackage

// File: rtl/fifo_burst_sched_if.sv
// Request/status bundle between the burst scheduler and its FIFO/SDRAM surroundings.
interface fifo_burst_sched_if;
    import fifo_burst_sched_pkg::*;

    logic              sdram_init_done;
    logic [LEN_W-1:0]  burst_num;
    logic [LEN_W-1:0]  wr_fifo_num;
    logic [LEN_W-1:0]  rd_fifo_num;
    logic              rd_enable;
    logic              sdram_ack;
    logic              sdram_done;
    logic              sdram_wr_req;
    logic              sdram_rd_req;
    logic [ADDR_W-1:0] sdram_addr;
    logic [LEN_W-1:0]  sdram_len;
    logic [ADDR_W-1:0] stored_cnt;
    logic              busy;
    logic              err_timeout;

    modport master (
        input  sdram_init_done, burst_num, wr_fifo_num, rd_fifo_num, rd_enable,
               sdram_ack, sdram_done,
        output sdram_wr_req, sdram_rd_req, sdram_addr, sdram_len, stored_cnt,
               busy, err_timeout
    );

    modport slave (
        output sdram_init_done, burst_num, wr_fifo_num, rd_fifo_num, rd_enable,
               sdram_ack, sdram_done,
        input  sdram_wr_req, sdram_rd_req, sdram_addr, sdram_len, stored_cnt,
               busy, err_timeout
    );

endinterface

// File: rtl/fifo_burst_sched_ring_ptr.sv
// One ring pointer: advances by a finished burst length and reports the clipped length of the next burst.
module ring_ptr
    import fifo_burst_sched_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_DEPTH = DEF_ADDR_DEPTH
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              advance_i,
    input  logic [LEN_W-1:0]  len_i,
    input  logic [LEN_W-1:0]  burst_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic [LEN_W-1:0]  clip_o
);

    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] ptr_d;
    logic [ADDR_W-1:0] ptrSum;

    // Lengths are pre-clipped, so the sum can only land exactly on the ring end.
    always_comb begin
        ptrSum = ptr_q + {{(ADDR_W-LEN_W){1'b0}}, len_i};
        ptr_d  = ptr_q;
        if (advance_i) begin
            ptr_d = (ptrSum >= ADDR_DEPTH) ? ptrSum - ADDR_DEPTH : ptrSum;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o  = ptr_q;
    assign clip_o = clipLen(burst_i, ADDR_DEPTH - ptr_q);

endmodule

// File: rtl/fifo_burst_sched.sv
// Round-robin scheduler moving fixed bursts between the UART FIFOs and an SDRAM ring buffer.
module fifo_burst_sched
    import fifo_burst_sched_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_DEPTH  = DEF_ADDR_DEPTH,
    parameter logic [LEN_W-1:0]  FIFO_DEPTH  = DEF_FIFO_DEPTH,
    parameter logic [15:0]       ACK_TIMEOUT = DEF_ACK_TIMEOUT
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    fifo_burst_sched_if.master bus
);

    state_t            state_q;
    logic              lastWasWrite_q;
    logic [15:0]       timeoutCnt_q;
    logic              wrReq_q;
    logic              rdReq_q;
    logic [ADDR_W-1:0] addr_q;
    logic [LEN_W-1:0]  len_q;
    logic [ADDR_W-1:0] stored_q;
    logic              busy_q;
    logic              errTimeout_q;

    logic [ADDR_W-1:0] wrPtr;
    logic [ADDR_W-1:0] rdPtr;
    logic [LEN_W-1:0]  wrClip;
    logic [LEN_W-1:0]  rdClip;
    logic              wrAdvance;
    logic              rdAdvance;

    logic [ADDR_W-1:0] burstWide;
    logic [ADDR_W-1:0] lenWide;
    logic [ADDR_W:0]   storedPlusBurst;
    logic [LEN_W:0]    rdFifoPlusBurst;
    logic              wrEligible;
    logic              rdEligible;
    logic              pickWrite;
    logic              ackExpired;

    assign burstWide       = {{(ADDR_W-LEN_W){1'b0}}, bus.burst_num};
    assign lenWide         = {{(ADDR_W-LEN_W){1'b0}}, len_q};
    assign storedPlusBurst = {1'b0, stored_q} + {1'b0, burstWide};
    assign rdFifoPlusBurst = {1'b0, bus.rd_fifo_num} + {1'b0, bus.burst_num};

    // Free read-FIFO room is checked as usedw+burst <= depth to avoid an underflowing subtraction.
    assign wrEligible = bus.sdram_init_done && (bus.burst_num != '0)
                     && (bus.wr_fifo_num >= bus.burst_num)
                     && (storedPlusBurst <= {1'b0, ADDR_DEPTH});
    assign rdEligible = bus.sdram_init_done && bus.rd_enable && (bus.burst_num != '0)
                     && (stored_q >= burstWide)
                     && (rdFifoPlusBurst <= {1'b0, FIFO_DEPTH});
    assign pickWrite  = wrEligible && (!rdEligible || !lastWasWrite_q);
    assign ackExpired = (timeoutCnt_q == ACK_TIMEOUT - 16'd1);

    assign wrAdvance = (state_q == WR_WAIT) && bus.sdram_done;
    assign rdAdvance = (state_q == RD_WAIT) && bus.sdram_done;

    ring_ptr #(.ADDR_DEPTH(ADDR_DEPTH)) wr_ptr (
        .clk_i     (sys_clk),
        .rst_i     (sys_rst),
        .advance_i (wrAdvance),
        .len_i     (len_q),
        .burst_i   (bus.burst_num),
        .ptr_o     (wrPtr),
        .clip_o    (wrClip)
    );

    ring_ptr #(.ADDR_DEPTH(ADDR_DEPTH)) rd_ptr (
        .clk_i     (sys_clk),
        .rst_i     (sys_rst),
        .advance_i (rdAdvance),
        .len_i     (len_q),
        .burst_i   (bus.burst_num),
        .ptr_o     (rdPtr),
        .clip_o    (rdClip)
    );

    // Grants only from IDLE, so a finished burst always leaves one idle cycle before the next.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q        <= IDLE;
            lastWasWrite_q <= 1'b0;
            timeoutCnt_q   <= '0;
            wrReq_q        <= 1'b0;
            rdReq_q        <= 1'b0;
            addr_q         <= '0;
            len_q          <= '0;
            stored_q       <= '0;
            busy_q         <= 1'b0;
            errTimeout_q   <= 1'b0;
        end else begin
            errTimeout_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    timeoutCnt_q <= '0;
                    if (wrEligible || rdEligible) begin
                        lastWasWrite_q <= pickWrite;
                        addr_q         <= pickWrite ? wrPtr : rdPtr;
                        len_q          <= pickWrite ? wrClip : rdClip;
                        wrReq_q        <= pickWrite;
                        rdReq_q        <= !pickWrite;
                        busy_q         <= 1'b1;
                        state_q        <= pickWrite ? WR_REQ : RD_REQ;
                    end
                end
                WR_REQ, RD_REQ: begin
                    if (bus.sdram_ack) begin
                        wrReq_q <= 1'b0;
                        rdReq_q <= 1'b0;
                        state_q <= (state_q == WR_REQ) ? WR_WAIT : RD_WAIT;
                    end else if (ackExpired) begin
                        wrReq_q      <= 1'b0;
                        rdReq_q      <= 1'b0;
                        errTimeout_q <= 1'b1;
                        busy_q       <= 1'b0;
                        state_q      <= IDLE;
                    end else begin
                        timeoutCnt_q <= timeoutCnt_q + 16'd1;
                    end
                end
                WR_WAIT: begin
                    if (bus.sdram_done) begin
                        stored_q <= stored_q + lenWide;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                RD_WAIT: begin
                    if (bus.sdram_done) begin
                        stored_q <= stored_q - lenWide;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.sdram_wr_req = wrReq_q;
    assign bus.sdram_rd_req = rdReq_q;
    assign bus.sdram_addr   = addr_q;
    assign bus.sdram_len    = len_q;
    assign bus.stored_cnt   = stored_q;
    assign bus.busy         = busy_q;
    assign bus.err_timeout  = errTimeout_q;

endmodule

// File: tb/tb_fifo_burst_sched.sv
// Directed and randomized bench for fifo_burst_sched on a 40-word ring, checked against a transaction-level model.
module tb_fifo_burst_sched;

    localparam int DEPTH   = 40;
    localparam int FDEPTH  = 1023;
    localparam int TIMEOUT = 10;

    logic clk = 1'b0;
    logic rst;

    fifo_burst_sched_if bus ();

    fifo_burst_sched #(
        .ADDR_DEPTH  (24'd40),
        .FIFO_DEPTH  (10'd1023),
        .ACK_TIMEOUT (16'd10)
    ) dut (
        .sys_clk (clk),
        .sys_rst (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int errors;
    int checks;
    int mWrPtr;
    int mRdPtr;
    int mStored;
    bit mLastWrite;
    int inBurst;
    int inWrf;
    int inRdf;
    bit inInit;
    bit inRden;
    int lastLatency;
    int lastKind;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit init, input int burst, input int wrf, input int rdf, input bit rden);
        inInit = init;
        inBurst = burst;
        inWrf = wrf;
        inRdf = rdf;
        inRden = rden;
        bus.sdram_init_done = init;
        bus.burst_num = 10'(burst);
        bus.wr_fifo_num = 10'(wrf);
        bus.rd_fifo_num = 10'(rdf);
        bus.rd_enable = rden;
    endtask

    // Eligibility and round-robin choice straight from the scheduling rules: 0 none, 1 write, 2 read.
    function automatic int modelPick();
        bit w;
        bit r;
        w = inInit && inBurst != 0 && inWrf >= inBurst && mStored + inBurst <= DEPTH;
        r = inInit && inRden && inBurst != 0 && mStored >= inBurst && FDEPTH - inRdf >= inBurst;
        if (w && r) return mLastWrite ? 2 : 1;
        if (w) return 1;
        if (r) return 2;
        return 0;
    endfunction

    task automatic checkAllZero(input string pfx);
        checkOutput({pfx, "WrReq"}, 32'(bus.sdram_wr_req), 0);
        checkOutput({pfx, "RdReq"}, 32'(bus.sdram_rd_req), 0);
        checkOutput({pfx, "Addr"}, 32'(bus.sdram_addr), 0);
        checkOutput({pfx, "Len"}, 32'(bus.sdram_len), 0);
        checkOutput({pfx, "Stored"}, 32'(bus.stored_cnt), 0);
        checkOutput({pfx, "Busy"}, 32'(bus.busy), 0);
        checkOutput({pfx, "Err"}, 32'(bus.err_timeout), 0);
    endtask

    task automatic waitGrant(output bit found);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!(bus.sdram_wr_req || bus.sdram_rd_req) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        lastLatency = waited;
        found = (waited < 20);
        checkOutput("grantSeen", 32'(found), 1);
    endtask

    task automatic noReq(input int n, input string tag);
        int seen;
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.sdram_wr_req || bus.sdram_rd_req || bus.busy) seen++;
        end
        checkOutput(tag, 32'(seen), 0);
    endtask

    // One full transaction acting as the SDRAM controller; burst_num is scrambled after grant on purpose.
    task automatic runBurst(input int ackDelay, input int doneDelay);
        int kind;
        int expAddr;
        int expLen;
        int highCycles;
        bit found;
        kind = modelPick();
        expAddr = (kind == 1) ? mWrPtr : mRdPtr;
        expLen = (inBurst < DEPTH - expAddr) ? inBurst : DEPTH - expAddr;
        waitGrant(found);
        if (!found) return;
        lastKind = kind;
        mLastWrite = (kind == 1);
        checkOutput("wrReq", 32'(bus.sdram_wr_req), 32'(kind == 1));
        checkOutput("rdReq", 32'(bus.sdram_rd_req), 32'(kind == 2));
        checkOutput("addr", 32'(bus.sdram_addr), 32'(expAddr));
        checkOutput("len", 32'(bus.sdram_len), 32'(expLen));
        bus.burst_num = 10'($urandom_range(1023, 0));
        highCycles = 0;
        for (int i = 0; i <= ackDelay; i++) begin
            if (bus.sdram_wr_req || bus.sdram_rd_req) highCycles++;
            bus.sdram_done = 1'($urandom_range(1, 0));
            bus.sdram_ack = (i == ackDelay);
            @(negedge clk);
        end
        bus.sdram_ack = 1'b0;
        bus.sdram_done = 1'b0;
        checkOutput("reqHighCycles", 32'(highCycles), 32'(ackDelay + 1));
        checkOutput("reqDropped", 32'(bus.sdram_wr_req | bus.sdram_rd_req), 0);
        checkOutput("busyWait", 32'(bus.busy), 1);
        for (int i = 0; i < doneDelay; i++) begin
            bus.sdram_ack = 1'($urandom_range(1, 0));
            @(negedge clk);
        end
        bus.sdram_ack = 1'b0;
        bus.sdram_done = 1'b1;
        bus.burst_num = 10'(inBurst);
        @(negedge clk);
        bus.sdram_done = 1'b0;
        if (kind == 1) begin
            mWrPtr = mWrPtr + expLen;
            if (mWrPtr >= DEPTH) mWrPtr = mWrPtr - DEPTH;
            mStored = mStored + expLen;
        end else begin
            mRdPtr = mRdPtr + expLen;
            if (mRdPtr >= DEPTH) mRdPtr = mRdPtr - DEPTH;
            mStored = mStored - expLen;
        end
        checkOutput("storedCnt", 32'(bus.stored_cnt), 32'(mStored));
        checkOutput("gapNoReq", 32'(bus.sdram_wr_req | bus.sdram_rd_req), 0);
        checkOutput("gapIdle", 32'(bus.busy), 0);
        checkOutput("addrHeld", 32'(bus.sdram_addr), 32'(expAddr));
        checkOutput("lenHeld", 32'(bus.sdram_len), 32'(expLen));
    endtask

    task automatic runTimeout();
        int kind;
        int highCycles;
        int errSeen;
        bit found;
        kind = modelPick();
        waitGrant(found);
        if (!found) return;
        mLastWrite = (kind == 1);
        checkOutput("toWrReq", 32'(bus.sdram_wr_req), 32'(kind == 1));
        highCycles = 0;
        errSeen = 0;
        while ((bus.sdram_wr_req || bus.sdram_rd_req) && highCycles < 3 * TIMEOUT) begin
            highCycles++;
            if (bus.err_timeout) errSeen++;
            @(negedge clk);
        end
        checkOutput("toReqCycles", 32'(highCycles), TIMEOUT);
        checkOutput("toNoEarlyErr", 32'(errSeen), 0);
        checkOutput("toErr", 32'(bus.err_timeout), 1);
        checkOutput("toIdle", 32'(bus.busy), 0);
        applyStimulus(1'b1, 0, 0, 0, 1'b0);
        @(negedge clk);
        checkOutput("toErrPulse", 32'(bus.err_timeout), 0);
        checkOutput("toStored", 32'(bus.stored_cnt), 32'(mStored));
    endtask

    initial begin
        bit found;
        errors = 0;
        checks = 0;
        mWrPtr = 0;
        mRdPtr = 0;
        mStored = 0;
        mLastWrite = 1'b0;
        lastKind = 0;
        rst = 1'b1;
        bus.sdram_ack = 1'b0;
        bus.sdram_done = 1'b0;
        applyStimulus(1'b0, 0, 0, 0, 1'b0);
        repeat (3) @(negedge clk);
        checkAllZero("reset");
        rst = 1'b0;

        // First write from an empty ring: ack three cycles after the request rises.
        applyStimulus(1'b1, 16, 16, 0, 1'b0);
        runBurst(3, 17);

        // Drain, then write up to the ring end where the burst is shortened.
        applyStimulus(1'b1, 16, 0, 0, 1'b1);
        runBurst(2, 5);
        applyStimulus(1'b1, 16, 16, 0, 1'b0);
        runBurst(1, 4);
        runBurst(0, 3);
        checkOutput("backToBack", 32'(lastLatency), 0);
        checkOutput("wrapPtr", 32'(mWrPtr), 0);
        runBurst(1, 2);
        noReq(6, "fullBlocksWrite");
        checkOutput("storedFull", 32'(bus.stored_cnt), 40);

        // Keep both kinds eligible so only round-robin decides.
        applyStimulus(1'b1, 8, 0, 0, 1'b1);
        runBurst(1, 1);
        applyStimulus(1'b1, 4, 1023, 0, 1'b1);
        for (int it = 0; it < 6; it++) begin
            runBurst($urandom_range(4, 0), $urandom_range(6, 0));
            checkOutput("rrAlternate", 32'(lastKind), (it % 2 == 0) ? 1 : 2);
        end

        // Read-FIFO room gating.
        applyStimulus(1'b1, 16, 0, 1010, 1'b1);
        noReq(6, "rdRoomBlocks");
        applyStimulus(1'b1, 16, 0, 1007, 1'b1);
        runBurst(2, 3);
        checkOutput("rdRoomGrant", 32'(lastKind), 2);

        applyStimulus(1'b1, 4, 1023, 0, 1'b0);
        runTimeout();

        for (int it = 0; it < 40; it++) begin
            applyStimulus($urandom_range(9, 0) != 0,
                          ($urandom_range(7, 0) == 0) ? 0 : $urandom_range(20, 1),
                          $urandom_range(30, 0),
                          $urandom_range(1023, 990),
                          1'($urandom_range(1, 0)));
            if (modelPick() == 0) begin
                noReq(4, "randNoGrant");
            end else begin
                runBurst($urandom_range(8, 0), $urandom_range(6, 0));
            end
        end

        // Reset in the middle of an accepted burst discards it entirely.
        applyStimulus(1'b1, 1, 1023, 0, 1'b1);
        waitGrant(found);
        bus.sdram_ack = 1'b1;
        @(negedge clk);
        bus.sdram_ack = 1'b0;
        checkOutput("preRstBusy", 32'(bus.busy), 32'(found));
        rst = 1'b1;
        @(negedge clk);
        checkAllZero("midRst");
        applyStimulus(1'b1, 0, 0, 0, 1'b0);
        rst = 1'b0;
        mWrPtr = 0;
        mRdPtr = 0;
        mStored = 0;
        mLastWrite = 1'b0;
        @(negedge clk);
        bus.sdram_done = 1'b1;
        @(negedge clk);
        bus.sdram_done = 1'b0;
        checkOutput("strayDone", 32'(bus.stored_cnt), 0);
        applyStimulus(1'b1, 8, 16, 0, 1'b0);
        runBurst(1, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
